// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one shared 8-bit adder walks the
// operands LSB byte first, chaining the registered carry between bytes.

module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {8'd0, cin};
  assign sum   = total[7:0];
  assign cout  = total[8];
endmodule

module mp_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [8*NBYTES-1:0] a_in,
  input  logic [8*NBYTES-1:0] b_in,
  input  logic                sub,
  input  logic                cin_in,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                ovf,
  output logic                zero
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            carry_reg;
  logic [IW-1:0]   idx_reg;
  logic [W-1:0]    result_reg;
  logic            cout_reg;
  logic            ovf_reg;
  logic            zero_reg;
  logic            start_ready_reg;
  logic            res_valid_reg;

  logic [7:0] a_bytes [NBYTES];
  logic [7:0] b_bytes [NBYTES];
  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic [7:0] sum_byte;
  logic       sum_cout;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign a_bytes[gi] = a_reg[gi*8 +: 8];
      assign b_bytes[gi] = b_reg[gi*8 +: 8];
    end
  endgenerate

  assign a_byte = a_bytes[idx_reg];
  assign b_byte = b_bytes[idx_reg];

  adder_8bit u_adder (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry_reg),
    .sum  (sum_byte),
    .cout (sum_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      a_reg           <= '0;
      b_reg           <= '0;
      carry_reg       <= 1'b0;
      idx_reg         <= '0;
      result_reg      <= '0;
      cout_reg        <= 1'b0;
      ovf_reg         <= 1'b0;
      zero_reg        <= 1'b0;
      start_ready_reg <= 1'b1;
      res_valid_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_valid && start_ready_reg) begin
            // B is stored pre-inverted for subtract so RUN is a plain add.
            a_reg           <= a_in;
            b_reg           <= sub ? ~b_in : b_in;
            carry_reg       <= sub ? 1'b1 : cin_in;
            idx_reg         <= '0;
            start_ready_reg <= 1'b0;
            state_reg       <= RUN;
          end
        end
        RUN: begin
          result_reg[idx_reg*8 +: 8] <= sum_byte;
          carry_reg                  <= sum_cout;
          if (idx_reg == LAST_IDX) begin
            cout_reg      <= sum_cout;
            ovf_reg       <= (a_byte[7] == b_byte[7]) && (sum_byte[7] != a_byte[7]);
            zero_reg      <= (sum_byte == 8'd0) && (result_reg[W-9:0] == '0);
            res_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (res_valid_reg && res_ready) begin
            res_valid_reg   <= 1'b0;
            start_ready_reg <= 1'b1;
            state_reg       <= IDLE;
          end
        end
        default: begin
          state_reg       <= IDLE;
          start_ready_reg <= 1'b1;
          res_valid_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = start_ready_reg;
  assign res_valid   = res_valid_reg;
  assign result      = result_reg;
  assign cout        = cout_reg;
  assign ovf         = ovf_reg;
  assign zero        = zero_reg;
endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq: directed vectors push expectations, a
// monitor pops and compares on every result handshake.

module tb_mp_add_seq;
  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         sub = 1'b0;
  logic         cin_in = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int popped = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.NBYTES(NBYTES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .sub         (sub),
    .cin_in      (cin_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .ovf         (ovf),
    .zero        (zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: one comparison per accepted result.
  initial begin
    forever begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%0h expected none", result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          popped++;
          check("result", 64'(result), 64'(e.res));
          check("flags", 64'({cout, ovf, zero}), 64'({e.c, e.o, e.z}));
          $display("result 0x%08h cout=%0d ovf=%0d zero=%0d", result, cout, ovf, zero);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!start_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!start_ready) check("start_ready_timeout", 64'(start_ready), 64'd1);
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ci);
    wait_ready();
    a_in = a; b_in = b; sub = s; cin_in = ci; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  // hold: DONE cycles with res_ready low; poke: spam start_valid with junk while busy.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic ci,
                       input logic [W-1:0] er, input logic ec, input logic eo,
                       input logic ez, input int hold, input logic poke);
    int n = 0;
    exp_t e;
    accept(a, b, s, ci);
    e.res = er; e.c = ec; e.o = eo; e.z = ez;
    exp_q.push_back(e);
    if (poke) begin
      a_in = 32'hDEAD_BEEF; b_in = 32'h1234_5678; sub = ~s; start_valid = 1'b1;
    end
    while (!res_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("latency", 64'(n), 64'(NBYTES));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'({res_valid, start_ready}), 64'b10);
      check("hold_result", 64'(result), 64'(er));
      check("hold_flags", 64'({cout, ovf, zero}), 64'({ec, eo, ez}));
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("post_hs", 64'({res_valid, start_ready}), 64'b01);
    if (poke) begin
      @(posedge clk); #1;
      check("post_hs_idle", 64'({res_valid, start_ready}), 64'b01);
      check("post_hs_keep", 64'(result), 64'(er));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_handshake", 64'({res_valid, start_ready}), 64'b01);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({cout, ovf, zero}), 64'd0);

    do_op(32'h0000_00FF, 32'h0000_0001, 0, 0, 32'h0000_0100, 0, 0, 0, 0, 0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0, 1, 0, 0);
    do_op(32'h0000_0005, 32'h0000_0007, 1, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    do_op(32'h0000_0007, 32'h0000_0005, 1, 0, 32'h0000_0002, 1, 0, 0, 0, 0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1, 0, 0, 0);
    do_op(32'h8000_0000, 32'h0000_0001, 1, 0, 32'h7FFF_FFFF, 1, 1, 0, 0, 0);
    do_op(32'h1234_5678, 32'h1111_1111, 0, 1, 32'h2345_678A, 0, 0, 0, 0, 0);
    do_op(32'h0000_000A, 32'h0000_0003, 1, 1, 32'h0000_0007, 1, 0, 0, 0, 0);
    do_op(32'h00FF_00FF, 32'h0001_0001, 0, 0, 32'h0100_0100, 0, 0, 0, 3, 1);

    // Abort during byte 2 of RUN; nothing is queued for this operation.
    accept(32'h0102_0304, 32'h0101_0101, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_handshake", 64'({res_valid, start_ready}), 64'b01);
    check("abort_result", 64'(result), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_valid", 64'(res_valid), 64'd0);

    do_op(32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0000_0000, 1, 1, 1, 0, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("results_seen", 64'(popped), 64'd10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer that reuses one adder_8bit instance to add two NBYTES-wide operands, one byte per clock, LSB first.
- The 8-bit carry-out is registered and chained into the next byte's carry-in.
- Operands enter and results leave through valid/ready handshakes.
- Sits between a register-file/ALU front end and consumers needing wide arithmetic without a wide ripple adder.

Parameters:
- NBYTES, 4, operand width in bytes (>=2); total width W = 8*NBYTES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start_valid  input  1  operation request.
- start_ready  output  1  block can accept a request.
- a_in  input  W  operand A.
- b_in  input  W  operand B.
- sub  input  1  0: A+B+cin_in; 1: A-B (A + ~B + 1, cin_in ignored).
- cin_in  input  1  carry-in for add.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- result  output  W  sum/difference.
- cout  output  1  final carry-out; for subtract, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset:
  - Applies when rst_n is low at a rising clk edge.
  - State goes to IDLE; result, cout, ovf, zero, res_valid = 0; start_ready = 1 the cycle after.
  - Reset mid-RUN or mid-DONE aborts the operation; no partial result is ever flagged valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1, res_valid = 0.
  - On start_valid & start_ready at an edge:
    - Capture a_in into the A register.
    - Capture b_in into the B register, or ~b_in if sub = 1.
    - Carry register = sub ? 1 : cin_in.
    - Byte index = 0; go to RUN.
- RUN:
  - start_ready = 0.
  - Each cycle the adder sees A[idx], B[idx] (already inverted for subtract) and the carry register.
  - At the edge: result[idx] = adder sum, carry register = adder cout, idx increments.
  - When idx == NBYTES-1 at the edge:
    - cout = adder cout.
    - ovf = (A msb == Beff msb) & (sum msb != A msb).
    - zero = (final result == 0).
    - Go to DONE.
  - RUN lasts exactly NBYTES cycles.
- DONE:
  - res_valid = 1; result/cout/ovf/zero held stable while res_ready = 0.
  - On res_ready at an edge: go to IDLE.
  - Outputs keep their last values after handshake until the next operation overwrites them byte-by-byte.
  - res_valid drops the cycle after the handshake.
- Latency: res_valid first asserted NBYTES edges after the accept edge.
  - Throughput: one operation per NBYTES+2 cycles minimum (accept, NBYTES RUN, DONE handshake, back to IDLE).
- Handshake rules:
  - start_valid outside IDLE is ignored; no queueing.
  - Operand inputs are sampled only at the accept edge; later changes have no effect.
- Index counter width: clog2(NBYTES); it never wraps past NBYTES-1 inside RUN.
- Simultaneous events: res_ready in the same cycle DONE is entered has no effect; the handshake counts only while res_valid = 1.

Test Plan:
- Byte carry ripple (NBYTES=4): A=0x000000FF, B=0x00000001, sub=0, cin_in=0 -> result=0x00000100, cout=0, ovf=0, zero=0; res_valid high 4 edges after accept.
- Full-width carry: A=0xFFFFFFFF, B=0x00000001, sub=0 -> result=0x00000000, cout=1, zero=1, ovf=0.
- Subtract: A=5, B=7, sub=1 -> result=0xFFFFFFFE, cout=0 (borrow), ovf=0. Then A=7, B=5 -> result=2, cout=1.
- Signed overflow: A=0x7FFFFFFF, B=1, sub=0 -> result=0x80000000, ovf=1.
  - A=0x80000000, B=1, sub=1 -> result=0x7FFFFFFF, ovf=1.
- Backpressure and ignored requests:
  - Hold res_ready=0 for 3 cycles in DONE: result and flags stable, start_ready=0, start_valid pulses during RUN/DONE produce no new operation.
  - After res_ready=1: IDLE, start_ready=1.
- Reset mid-operation: drive rst_n low for 1 edge at RUN byte 2 -> next cycle IDLE, res_valid=0, result=0.
  - A new request then completes with the correct value.
